// File: rtl/bsg_manycore_io_link_arbiter.sv
// Round-robin arbiter sharing one manycore io_link among num_req_p requesters,
// with in-order response routing via a requester-ID FIFO. Optional grant stats: BSG_MANYCORE_IO_ARB_STATS_EN.

module bsg_manycore_io_link_arbiter_lane #(
  parameter int lane_id_p    = 0,
  parameter int max_out_p    = 8,
  parameter int cnt_width_lp = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    inc_i,
  input  logic                    dec_i,
  output logic [cnt_width_lp-1:0] cnt_o,
  output logic                    avail_o
`ifdef BSG_MANYCORE_IO_ARB_STATS_EN
  ,output logic [31:0]            grants_o
`endif
);
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i)      cnt_d = cnt_q + cnt_width_lp'(1);
    else if (!inc_i && dec_i) cnt_d = cnt_q - cnt_width_lp'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;

  assign cnt_o   = cnt_q;
  assign avail_o = (cnt_q < cnt_width_lp'(max_out_p));

`ifdef BSG_MANYCORE_IO_ARB_STATS_EN
  logic [31:0] grants_q, grants_d;

  always_comb begin
    grants_d = grants_q;
    if (inc_i) grants_d = grants_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) grants_q <= '0;
    else         grants_q <= grants_d;

  assign grants_o = grants_q;

  final $display("io_link_arbiter requester %0d grants %0d", lane_id_p, grants_q);
`endif
endmodule

module bsg_manycore_io_link_arbiter #(
  parameter int num_req_p      = 2,
  parameter int packet_width_p = 80,
  parameter int return_width_p = 40,
  parameter int max_out_p      = 8,
  parameter int id_width_lp    = (num_req_p <= 1) ? 1 : $clog2(num_req_p),
  parameter int cnt_width_lp   = $clog2(max_out_p + 1)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p*packet_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]                req_ready_o,
  output logic                                out_v_o,
  output logic [packet_width_p-1:0]           out_data_o,
  input  logic                                out_ready_i,
  input  logic                                resp_v_i,
  input  logic [return_width_p-1:0]           resp_data_i,
  output logic                                resp_yumi_o,
  output logic [num_req_p-1:0]                resp_v_o,
  output logic [return_width_p-1:0]           resp_data_o,
  input  logic [num_req_p-1:0]                resp_yumi_i,
  output logic [num_req_p*cnt_width_lp-1:0]   credits_o,
  output logic                                error_o
`ifdef BSG_MANYCORE_IO_ARB_STATS_EN
  ,output logic [num_req_p*32-1:0]            stats_o
`endif
);
  localparam int ptr_width_lp = (max_out_p <= 1) ? 1 : $clog2(max_out_p);

  logic [num_req_p-1:0][packet_width_p-1:0] req_data_a;
  logic [num_req_p-1:0][cnt_width_lp-1:0]   credits_a;
  logic [num_req_p-1:0]                     avail, elig, grant_oh, head_oh;

  logic                      out_v_q, out_v_d;
  logic [packet_width_p-1:0] out_data_q, out_data_d;
  logic [id_width_lp-1:0]    rr_q, rr_d;
  logic                      error_q, error_d;

  logic [max_out_p-1:0][id_width_lp-1:0] fifo_mem_q, fifo_mem_d;
  logic [ptr_width_lp-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_width_lp-1:0]               fifo_cnt_q, fifo_cnt_d;

  logic                   load_ok, fifo_full, fifo_empty;
  logic                   grant_v, push, pop, drop;
  logic [id_width_lp-1:0] grant_id, head;

  assign req_data_a = req_data_i;
  assign credits_o  = credits_a;

  assign fifo_full  = (fifo_cnt_q == cnt_width_lp'(max_out_p));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign head       = fifo_mem_q[rd_ptr_q];
  // The output stage may take a new packet if empty or draining this cycle
  assign load_ok    = ~out_v_q | out_ready_i;

  genvar gi;
  generate
    for (gi = 0; gi < num_req_p; gi++) begin : g_lane
      assign elig[gi]     = req_v_i[gi] & avail[gi] & ~fifo_full & load_ok & ~reset_i;
      assign grant_oh[gi] = grant_v & (grant_id == id_width_lp'(gi));
      assign head_oh[gi]  = (head == id_width_lp'(gi));

      bsg_manycore_io_link_arbiter_lane #(
        .lane_id_p    (gi),
        .max_out_p    (max_out_p),
        .cnt_width_lp (cnt_width_lp)
      ) lane (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .inc_i    (grant_oh[gi]),
        .dec_i    (pop & head_oh[gi]),
        .cnt_o    (credits_a[gi]),
        .avail_o  (avail[gi])
`ifdef BSG_MANYCORE_IO_ARB_STATS_EN
        ,.grants_o (stats_o[gi*32 +: 32])
`endif
      );
    end
  endgenerate

  always_comb begin
    int idx;
    idx      = 0;
    grant_v  = 1'b0;
    grant_id = '0;
    for (int off = 0; off < num_req_p; off++) begin
      idx = (int'(rr_q) + off) % num_req_p;
      if (!grant_v && elig[idx]) begin
        grant_v  = 1'b1;
        grant_id = id_width_lp'(idx);
      end
    end
  end

  assign req_ready_o = grant_oh;
  assign push        = grant_v;
  assign pop         = resp_v_i & ~fifo_empty & |(resp_yumi_i & head_oh) & ~reset_i;
  // A response with nothing outstanding is swallowed and flagged
  assign drop        = resp_v_i & fifo_empty & ~reset_i;
  assign resp_v_o    = (resp_v_i & ~fifo_empty & ~reset_i) ? head_oh : '0;
  assign resp_yumi_o = pop | drop;
  assign resp_data_o = resp_data_i;
  assign out_v_o     = out_v_q;
  assign out_data_o  = out_data_q;
  assign error_o     = error_q;

  always_comb begin
    out_v_d    = grant_v | (out_v_q & ~out_ready_i);
    out_data_d = grant_v ? req_data_a[grant_id] : out_data_q;
    rr_d       = rr_q;
    if (grant_v)
      rr_d = (grant_id == id_width_lp'(num_req_p - 1)) ? '0 : grant_id + id_width_lp'(1);
    error_d    = error_q | drop;
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = grant_id;
      wr_ptr_d = (wr_ptr_q == ptr_width_lp'(max_out_p - 1)) ? '0 : wr_ptr_q + ptr_width_lp'(1);
    end
    if (pop)
      rd_ptr_d = (rd_ptr_q == ptr_width_lp'(max_out_p - 1)) ? '0 : rd_ptr_q + ptr_width_lp'(1);
    fifo_cnt_d = fifo_cnt_q + cnt_width_lp'(push) - cnt_width_lp'(pop);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      rr_q       <= '0;
      error_q    <= 1'b0;
      fifo_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
      rr_q       <= rr_d;
      error_q    <= error_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end
endmodule

// File: tb/tb_bsg_manycore_io_link_arbiter.sv
// Directed bench for bsg_manycore_io_link_arbiter at default parameters (2 requesters, cap 8).
module tb_bsg_manycore_io_link_arbiter;
  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [1:0]   req_v_i;
  logic [159:0] req_data_i;
  logic [1:0]   req_ready_o;
  logic         out_v_o;
  logic [79:0]  out_data_o;
  logic         out_ready_i;
  logic         resp_v_i;
  logic [39:0]  resp_data_i;
  logic         resp_yumi_o;
  logic [1:0]   resp_v_o;
  logic [39:0]  resp_data_o;
  logic [1:0]   resp_yumi_i;
  logic [7:0]   credits_o;
  logic         error_o;

  int checks = 0;
  int errors = 0;

  localparam logic [79:0] D0 = 80'hA0A1_A2A3_A4A5_A6A7_A8A9;
  localparam logic [79:0] D1 = 80'hB0B1_B2B3_B4B5_B6B7_B8B9;
  localparam logic [79:0] E0 = 80'hC0C1_C2C3_C4C5_C6C7_C8C9;
  localparam logic [79:0] E1 = 80'hD0D1_D2D3_D4D5_D6D7_D8D9;

  bsg_manycore_io_link_arbiter dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .out_v_o(out_v_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .resp_v_i(resp_v_i), .resp_data_i(resp_data_i), .resp_yumi_o(resp_yumi_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
    .credits_o(credits_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    req_v_i = '0; resp_v_i = 1'b0; resp_yumi_i = '0; out_ready_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
  endtask

  initial begin
    logic [1:0] e;
    logic [1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b10; seq[3] = 2'b01;
    reset_i = 1'b1; req_v_i = 2'b11; req_data_i = {D1, D0};
    out_ready_i = 1'b1; resp_v_i = 1'b1; resp_data_i = 40'h12_3456_789A; resp_yumi_i = 2'b11;
    #2;
    chk("rst_ready", req_ready_o, 2'b00);
    chk("rst_out_v", out_v_o, 1'b0);
    chk("rst_yumi", resp_yumi_o, 1'b0);
    chk("rst_resp_v", resp_v_o, 2'b00);
    chk("rst_credits", credits_o, 8'h00);
    chk("rst_error", error_o, 1'b0);
    do_reset();

    // single request, one-cycle latency, then its response
    req_v_i = 2'b01; #1;
    chk("t1_ready", req_ready_o, 2'b01);
    tick(); req_v_i = 2'b00; #1;
    chk("t1_out_v", out_v_o, 1'b1);
    chk("t1_out_data", out_data_o, D0);
    chk("t1_credits", credits_o, 8'h01);
    tick();
    chk("t1_drained", out_v_o, 1'b0);
    resp_v_i = 1'b1; resp_yumi_i = 2'b01; #1;
    chk("t1_resp_v", resp_v_o, 2'b01);
    chk("t1_yumi", resp_yumi_o, 1'b1);
    chk("t1_resp_data", resp_data_o, 40'h12_3456_789A);
    tick(); resp_v_i = 1'b0; #1;
    chk("t1_cred0", credits_o, 8'h00);
    chk("t1_noerr", error_o, 1'b0);

    // both requesting: alternate until the ID FIFO fills, then drain in order
    do_reset();
    req_v_i = 2'b11;
    for (int i = 0; i < 8; i++) begin
      e = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1 chk("t2_alt", req_ready_o, e);
      tick();
    end
    #1;
    chk("t2_credits", credits_o, 8'h44);
    chk("t2_full", req_ready_o, 2'b00);
    req_v_i = 2'b00; resp_v_i = 1'b1; resp_yumi_i = 2'b11;
    for (int i = 0; i < 8; i++) begin
      e = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1 chk("t2_route", resp_v_o, e);
      tick();
    end
    resp_v_i = 1'b0; #1;
    chk("t2_cred0", credits_o, 8'h00);

    // requester 0 streams to its cap; a pop re-opens arbitration next cycle
    do_reset();
    req_v_i = 2'b01;
    for (int i = 0; i < 8; i++) begin
      #1 chk("t3_stream", req_ready_o, 2'b01);
      tick();
    end
    #1;
    chk("t3_credits", credits_o, 8'h08);
    req_v_i = 2'b11; #1;
    chk("t3_masked", req_ready_o, 2'b00);
    resp_v_i = 1'b1; resp_yumi_i = 2'b01; #1;
    chk("t3_pop_v", resp_v_o, 2'b01);
    chk("t3_pop_nogrant", req_ready_o, 2'b00);
    tick(); resp_v_i = 1'b0; #1;
    chk("t3_req1", req_ready_o, 2'b10);
    tick(); req_v_i = 2'b00; #1;
    chk("t3_cred_after", credits_o, 8'h17);

    // issue order 0,1,1,0 then in-order responses
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_v_i = seq[i]; #1;
      chk("t4_issue", req_ready_o, seq[i]);
      tick();
    end
    req_v_i = 2'b00; #1;
    chk("t4_credits", credits_o, 8'h22);
    resp_v_i = 1'b1; resp_yumi_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t4_route", resp_v_o, seq[i]);
      tick();
    end
    resp_v_i = 1'b0; #1;
    chk("t4_cred0", credits_o, 8'h00);

    // orphan response sets sticky error; async reset clears mid-stream
    do_reset();
    resp_v_i = 1'b1; resp_yumi_i = 2'b00; #1;
    chk("t5_drop_yumi", resp_yumi_o, 1'b1);
    chk("t5_drop_v", resp_v_o, 2'b00);
    tick(); resp_v_i = 1'b0; #1;
    chk("t5_error", error_o, 1'b1);
    tick(); tick();
    chk("t5_error_held", error_o, 1'b1);
    req_v_i = 2'b01; #1;
    tick(); req_v_i = 2'b00; #1;
    chk("t5_pre_out_v", out_v_o, 1'b1);
    chk("t5_pre_credits", credits_o, 8'h01);
    reset_i = 1'b1; resp_v_i = 1'b1; req_v_i = 2'b01; #1;
    chk("t5_rst_out_v", out_v_o, 1'b0);
    chk("t5_rst_credits", credits_o, 8'h00);
    chk("t5_rst_error", error_o, 1'b0);
    chk("t5_rst_yumi", resp_yumi_o, 1'b0);
    chk("t5_rst_ready", req_ready_o, 2'b00);

    // back-pressure holds the output stage and blocks grants
    do_reset();
    req_v_i = 2'b01; #1;
    tick();
    req_data_i = {E1, E0}; req_v_i = 2'b11; out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t6_stall_ready", req_ready_o, 2'b00);
      chk("t6_stall_data", out_data_o, D0);
      chk("t6_stall_v", out_v_o, 1'b1);
      tick();
    end
    out_ready_i = 1'b1; #1;
    chk("t6_resume", req_ready_o, 2'b10);
    tick(); req_v_i = 2'b00; #1;
    chk("t6_new_data", out_data_o, E1);
    chk("t6_new_v", out_v_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
